// File: rtl/pinmux_gf_pkg.sv
// Shared types and helpers for the pinmux input glitch filter.
package pinmux_gf_pkg;

  typedef enum logic [0:0] {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } db_state_e;

  localparam int BYP_GF   = 0;
  localparam int BYP_DB   = 1;
  localparam int BYP_SYNC = 2;

  // Prescaler terminal value: 4^sel - 1.
  function automatic logic [5:0] pre_term(input logic [1:0] sel);
    case (sel)
      2'd0:    pre_term = 6'd0;
      2'd1:    pre_term = 6'd3;
      2'd2:    pre_term = 6'd15;
      default: pre_term = 6'd63;
    endcase
  endfunction

endpackage

// File: rtl/pinmux_gf_tick_gen.sv
// Sample-tick prescaler: tick every 4^sel clocks; a change of sel restarts the count
// without emitting a tick on the cycle the change is seen.
module pinmux_gf_tick_gen #(
  parameter int PRE_WIDTH = 6
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_sel,
  output logic       o_tick
);
  import pinmux_gf_pkg::*;

  logic [PRE_WIDTH-1:0] pre_q, pre_d, term;
  logic [1:0]           sel_q;
  logic                 sel_chg;

  assign term    = PRE_WIDTH'(pre_term(i_sel));
  assign sel_chg = (i_sel != sel_q);
  assign o_tick  = !sel_chg && (pre_q == term);

  always_comb begin
    pre_d = pre_q + PRE_WIDTH'(1);
    if (sel_chg || o_tick) pre_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pre_q <= '0;
      sel_q <= 2'd0;
    end else begin
      pre_q <= pre_d;
      sel_q <= i_sel;
    end
  end

endmodule

// File: rtl/pinmux_input_glitch_filter.sv
// Per-pin input conditioning: synchroniser, 3-sample glitch filter, stable-count debounce, edge pulses.
// PINMUX_GF_STATUS_EN adds a saturating glitch counter (o_glitch_cnt) with clear input.
module pinmux_input_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8,
  parameter int PRE_WIDTH   = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pad_in,
  input  logic                 i_ie,
  input  logic [1:0]           i_debounce_clk_sel,
  input  logic [2:0]           i_bypass,
  input  logic [CNT_WIDTH-1:0] i_db_thresh,
  output logic                 o_async_in,
  output logic                 o_filtered,
  output logic                 o_rise,
  output logic                 o_fall
`ifdef PINMUX_GF_STATUS_EN
  ,
  input  logic                 i_glitch_cnt_clr,
  output logic [7:0]           o_glitch_cnt
`endif
);
  import pinmux_gf_pkg::*;

  logic                   chain_in, sync_out, tick;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [2:0]             sr_q, sr_d;
  logic                   sr_uniform, gf_q, gf_d, gf_out;
  db_state_e              state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH:0]     cnt_inc;
  logic                   filt_q, filt_d, rise_q, fall_q;

  assign chain_in   = i_pad_in & i_ie;
  assign o_async_in = chain_in;
  assign sync_out   = i_bypass[BYP_SYNC] ? chain_in : sync_q[SYNC_STAGES-1];

  pinmux_gf_tick_gen #(.PRE_WIDTH(PRE_WIDTH)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_sel  (i_debounce_clk_sel),
    .o_tick (tick)
  );

  assign sr_d       = tick ? {sr_q[1:0], sync_out} : sr_q;
  assign sr_uniform = (sr_q == 3'b000) || (sr_q == 3'b111);
  assign gf_d       = sr_uniform ? sr_q[0] : gf_q;
  assign gf_out     = i_bypass[BYP_GF] ? sync_out : gf_q;
  assign cnt_inc    = {1'b0, cnt_q} + (CNT_WIDTH + 1)'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    filt_d  = filt_q;
    if (i_bypass[BYP_DB]) begin
      state_d = STABLE;
      cnt_d   = '0;
      filt_d  = gf_out;
    end else begin
      case (state_q)
        STABLE: begin
          if (gf_out != filt_q) begin
            if (i_db_thresh == '0) begin
              filt_d = gf_out;
            end else begin
              state_d = QUALIFY;
              cnt_d   = '0;
            end
          end
        end
        QUALIFY: begin
          if (gf_out == filt_q) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (tick) begin
            // Threshold is live, so lowering it mid-qualify completes on this tick.
            if (cnt_inc >= {1'b0, i_db_thresh}) begin
              filt_d  = gf_out;
              state_d = STABLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc[CNT_WIDTH-1:0];
            end
          end
        end
        default: state_d = STABLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q  <= '0;
      sr_q    <= 3'b000;
      gf_q    <= 1'b0;
      state_q <= STABLE;
      cnt_q   <= '0;
      filt_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], chain_in};
      sr_q    <= sr_d;
      gf_q    <= gf_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      rise_q  <= filt_d & ~filt_q;
      fall_q  <= ~filt_d & filt_q;
    end
  end

  assign o_filtered = filt_q;
  assign o_rise     = rise_q;
  assign o_fall     = fall_q;

`ifdef PINMUX_GF_STATUS_EN
  logic       uni_q, win_evt, reject;
  logic [1:0] inc;
  logic [8:0] sum;
  logic [7:0] gcnt_q, gcnt_d;

  // A glitch window is counted once, when the sample register first goes non-uniform.
  assign win_evt = uni_q & ~sr_uniform;
  assign reject  = (state_q == QUALIFY) && !i_bypass[BYP_DB] && (gf_out == filt_q);
  assign inc     = {1'b0, reject} + {1'b0, win_evt};
  assign sum     = {1'b0, gcnt_q} + {7'b0, inc};

  always_comb begin
    gcnt_d = sum[8] ? 8'hFF : sum[7:0];
    if (i_glitch_cnt_clr) gcnt_d = 8'h00;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      uni_q  <= 1'b1;
      gcnt_q <= 8'h00;
    end else begin
      uni_q  <= sr_uniform;
      gcnt_q <= gcnt_d;
    end
  end

  assign o_glitch_cnt = gcnt_q;
`endif

endmodule
